i2s_dac_tx: RTL and testbench

- Transmit-side counterpart of the mic capture path: serialises 16-bit audio samples onto the WM8731 DAC data line (AUD_DACDAT).
- The codec is bit-clock/LR-clock master. The block samples AUD_BCLK and AUD_DACLRCK in a single fast system clock domain (CLOCK_50 or adc_clk).
- Accepts samples through a valid/ready stream with a 2-entry buffer and sends each mono sample on both left and right channels.
- Sits after the decimator/processing chain, e.g. for monitoring playback.

---
 rtl/i2s_dac_tx.sv | 175 +++++++++++++++++
 tb/tb_i2s_dac_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx.sv
// I2S / left-justified DAC transmitter for the WM8731 (codec is clock master).
// Mono samples from a 2-entry stream buffer are sent on both channels.
`timescale 1ns/1ps
module i2s_dac_tx #(
    parameter int N         = 16,
    parameter bit I2S_MODE  = 1'b1,
    parameter int SLOT_BITS = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bclk,
    input  logic         daclrck,
    input  logic         x_valid,
    output logic         x_ready,
    input  logic [N-1:0] x_data,
    output logic         dacdat,
    output logic         underrun,
    output logic [15:0]  underrun_count,
    output logic         frame_start
);

    localparam int CW = $clog2(SLOT_BITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic          bclk_s1, bclk_s2, bclk_h;
    logic          lr_s1, lr_s2, lr_h;
    logic          bclk_fall, lr_fall, lr_rise;

    logic [N-1:0]  mem [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    count;
    logic          push, pop, empty;

    logic [N-1:0]  frame_reg;
    logic [N-1:0]  shift_reg;
    logic [CW-1:0] bit_cnt;
    logic          dacdat_q;
    logic [15:0]   ur_cnt_q;

    logic          load_right;
    logic [N-1:0]  load_val;
    logic [N-1:0]  src;

    assign bclk_fall = bclk_h & ~bclk_s2;
    assign lr_fall   = lr_h & ~lr_s2;
    assign lr_rise   = ~lr_h & lr_s2;

    assign empty    = (count == 2'd0);
    assign x_ready  = rst_n && (count != 2'd2);
    assign push     = x_valid && x_ready;
    assign pop      = lr_fall && !empty;
    assign src      = empty ? '0 : mem[rd_ptr];

    assign load_right = lr_rise && (state_q == LEFT);
    assign load_val   = lr_fall ? src : frame_reg;

    assign dacdat         = dacdat_q;
    assign underrun_count = ur_cnt_q;

    // Two-flop synchronisers plus a history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_h  <= 1'b0;
            lr_s1   <= 1'b0;
            lr_s2   <= 1'b0;
            lr_h    <= 1'b0;
        end else begin
            bclk_s1 <= bclk;
            bclk_s2 <= bclk_s1;
            bclk_h  <= bclk_s2;
            lr_s1   <= daclrck;
            lr_s2   <= lr_s1;
            lr_h    <= lr_s2;
        end
    end

    // Sample buffer: push from the stream, pop only at a left-channel start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= x_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Channel state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a left start is taken from any state, right only after left
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (lr_fall) state_d = LEFT;
            LEFT:    if (lr_fall) state_d = LEFT;
                     else if (lr_rise) state_d = RIGHT;
            RIGHT:   if (lr_fall) state_d = LEFT;
            default: state_d = IDLE;
        endcase
    end

    // Word loading at channel starts and bit shifting on BCLK falling edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_reg <= '0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            dacdat_q  <= 1'b0;
        end else if (lr_fall || load_right) begin
            if (lr_fall) begin
                frame_reg <= src;
            end
            if (I2S_MODE) begin
                shift_reg <= load_val;
                bit_cnt   <= '0;
                dacdat_q  <= 1'b0;
            end else begin
                shift_reg <= load_val << 1;
                bit_cnt   <= CW'(1);
                dacdat_q  <= load_val[N-1];
            end
        end else if (bclk_fall && state_q != IDLE) begin
            if (bit_cnt < CW'(N)) begin
                dacdat_q  <= shift_reg[N-1];
                shift_reg <= shift_reg << 1;
                bit_cnt   <= bit_cnt + CW'(1);
            end else begin
                dacdat_q  <= 1'b0;
            end
        end
    end

    // Status pulses and the saturating underrun counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun    <= 1'b0;
            frame_start <= 1'b0;
            ur_cnt_q    <= 16'd0;
        end else begin
            underrun    <= lr_fall && empty;
            frame_start <= lr_fall;
            if (lr_fall && empty && ur_cnt_q != 16'hFFFF) begin
                ur_cnt_q <= ur_cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: one I2S instance and one left-justified
// instance share the codec clocks and the input stream.
`timescale 1ns/1ps
module tb_i2s_dac_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bclk = 1'b1;
    logic        daclrck = 1'b1;
    logic        x_valid = 1'b0;
    logic [15:0] x_data = 16'h0;

    logic        a_x_ready, a_dacdat, a_underrun, a_frame_start;
    logic [15:0] a_underrun_count;
    logic        b_x_ready, b_dacdat, b_underrun, b_frame_start;
    logic [15:0] b_underrun_count;

    int passed = 0;
    int total  = 0;
    int ur_a = 0, fs_a = 0, ur_b = 0, fs_b = 0;

    i2s_dac_tx #(.N(16), .I2S_MODE(1'b1), .SLOT_BITS(32)) dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .bclk           (bclk),
        .daclrck        (daclrck),
        .x_valid        (x_valid),
        .x_ready        (a_x_ready),
        .x_data         (x_data),
        .dacdat         (a_dacdat),
        .underrun       (a_underrun),
        .underrun_count (a_underrun_count),
        .frame_start    (a_frame_start)
    );

    i2s_dac_tx #(.N(16), .I2S_MODE(1'b0), .SLOT_BITS(32)) dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .bclk           (bclk),
        .daclrck        (daclrck),
        .x_valid        (x_valid),
        .x_ready        (b_x_ready),
        .x_data         (x_data),
        .dacdat         (b_dacdat),
        .underrun       (b_underrun),
        .underrun_count (b_underrun_count),
        .frame_start    (b_frame_start)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (a_underrun)    ur_a++;
        if (a_frame_start) fs_a++;
        if (b_underrun)    ur_b++;
        if (b_frame_start) fs_b++;
    end

    typedef struct {
        logic [15:0] d;
        logic [31:0] e_i2s;
        logic [31:0] e_lj;
    } vec_t;

    vec_t tv[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // One BCLK period of 8 clk; optional push lands in the LRCK-edge cycle
    task automatic bclk_cycle(input logic lr, input logic do_push,
                              input logic [15:0] pd,
                              output logic sa, output logic sb,
                              output logic rdy);
        rdy = 1'b0;
        @(negedge clk);
        bclk = 1'b0;
        daclrck = lr;
        @(negedge clk);
        @(negedge clk);
        if (do_push) begin
            x_valid = 1'b1;
            x_data  = pd;
            rdy     = a_x_ready & b_x_ready;
        end
        @(negedge clk);
        x_valid = 1'b0;
        @(negedge clk);
        sa = a_dacdat;
        sb = b_dacdat;
        bclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame(input logic push_edge, input logic [15:0] pd,
                             output logic [31:0] la, output logic [31:0] ra,
                             output logic [31:0] lb, output logic [31:0] rb,
                             output logic rdy);
        logic sa, sb, r;
        rdy = 1'b0;
        for (int h = 0; h < 2; h++) begin
            for (int k = 0; k < 32; k++) begin
                bclk_cycle(h == 1, push_edge && h == 0 && k == 0, pd,
                           sa, sb, r);
                if (h == 0 && k == 0) rdy = r;
                if (h == 0) begin
                    la[31-k] = sa;
                    lb[31-k] = sb;
                end else begin
                    ra[31-k] = sa;
                    rb[31-k] = sb;
                end
            end
        end
    endtask

    task automatic try_push(input logic [15:0] d, output logic ra,
                            output logic rb);
        @(negedge clk);
        x_valid = 1'b1;
        x_data  = d;
        ra = a_x_ready;
        rb = b_x_ready;
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic chk_frame(input string nm, input logic [31:0] la,
                             input logic [31:0] ra, input logic [31:0] lb,
                             input logic [31:0] rb, input logic [31:0] ei,
                             input logic [31:0] el);
        chk({nm, " i2s left"}, la, ei);
        chk({nm, " i2s right"}, ra, ei);
        chk({nm, " lj left"}, lb, el);
        chk({nm, " lj right"}, rb, el);
    endtask

    initial begin
        logic [31:0] la, ra, lb, rb;
        logic        rdy, pa, pb, sa, sb;
        logic [31:0] acc;
        int          ua, ub, fa, fb;

        tv[0] = '{16'hA5C3, 32'h52E18000, 32'hA5C30000};
        tv[1] = '{16'h8001, 32'h40008000, 32'h80010000};
        tv[2] = '{16'hFFFF, 32'h7FFF8000, 32'hFFFF0000};
        tv[3] = '{16'h0001, 32'h00008000, 32'h00010000};
        tv[4] = '{16'h7FFE, 32'h3FFF0000, 32'h7FFE0000};
        tv[5] = '{16'h1234, 32'h091A0000, 32'h12340000};

        // power-on reset
        repeat (5) @(negedge clk);
        chk("rst x_ready", {30'd0, a_x_ready, b_x_ready}, 32'd0);
        chk("rst dacdat", {30'd0, a_dacdat, b_dacdat}, 32'd0);
        chk("rst count", {a_underrun_count, b_underrun_count}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("x_ready after rst", {30'd0, a_x_ready, b_x_ready}, 32'd3);

        // idle: BCLK runs but no LRCK fall, output stays low
        acc = '0;
        for (int k = 0; k < 4; k++) begin
            bclk_cycle(1'b1, 1'b0, 16'h0, sa, sb, rdy);
            acc = acc | {30'd0, sa, sb};
        end
        chk("idle dacdat", acc, 32'd0);

        // table-driven single-word frames
        for (int i = 0; i < 6; i++) begin
            try_push(tv[i].d, pa, pb);
            chk($sformatf("vec%0d accept", i), {30'd0, pa, pb}, 32'd3);
            ua = ur_a; fa = fs_a; ub = ur_b; fb = fs_b;
            run_frame(1'b0, 16'h0, la, ra, lb, rb, rdy);
            chk_frame($sformatf("vec%0d", i), la, ra, lb, rb,
                      tv[i].e_i2s, tv[i].e_lj);
            chk($sformatf("vec%0d frame_start", i),
                {16'(fs_a - fa), 16'(fs_b - fb)}, {16'd1, 16'd1});
            chk($sformatf("vec%0d underrun", i),
                {16'(ur_a - ua), 16'(ur_b - ub)}, 32'd0);
        end

        // backpressure: third push refused, order kept
        try_push(16'h1357, pa, pb);
        chk("bp push1", {30'd0, pa, pb}, 32'd3);
        try_push(16'hC0DE, pa, pb);
        chk("bp push2", {30'd0, pa, pb}, 32'd3);
        try_push(16'hBEEF, pa, pb);
        chk("bp push3 refused", {30'd0, pa, pb}, 32'd0);
        run_frame(1'b0, 16'h0, la, ra, lb, rb, rdy);
        chk_frame("bp word1", la, ra, lb, rb, 32'h09AB8000, 32'h13570000);
        chk("bp x_ready back", {30'd0, a_x_ready, b_x_ready}, 32'd3);
        run_frame(1'b0, 16'h0, la, ra, lb, rb, rdy);
        chk_frame("bp word2", la, ra, lb, rb, 32'h606F0000, 32'hC0DE0000);

        // push coincident with LRCK fall on an empty buffer
        ua = ur_a; ub = ur_b;
        run_frame(1'b1, 16'h5A5A, la, ra, lb, rb, rdy);
        chk("edge push ready", {31'd0, rdy}, 32'd1);
        chk_frame("edge underrun", la, ra, lb, rb, 32'd0, 32'd0);
        chk("edge ur pulse", {16'(ur_a - ua), 16'(ur_b - ub)},
            {16'd1, 16'd1});
        ua = ur_a; ub = ur_b;
        run_frame(1'b0, 16'h0, la, ra, lb, rb, rdy);
        chk_frame("edge next", la, ra, lb, rb, 32'h2D2D0000, 32'h5A5A0000);
        chk("edge next no ur", {16'(ur_a - ua), 16'(ur_b - ub)}, 32'd0);

        // underrun run of three frames from a clean count
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        ua = ur_a; ub = ur_b;
        acc = '0;
        for (int f = 0; f < 3; f++) begin
            run_frame(1'b0, 16'h0, la, ra, lb, rb, rdy);
            acc = acc | la | ra | lb | rb;
        end
        chk("ur3 data zero", acc, 32'd0);
        chk("ur3 pulses", {16'(ur_a - ua), 16'(ur_b - ub)}, {16'd3, 16'd3});
        chk("ur3 count", {a_underrun_count, b_underrun_count},
            {16'd3, 16'd3});

        // saturation
        @(negedge clk);
        force dut_a.ur_cnt_q = 16'hFFFF;
        force dut_b.ur_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut_a.ur_cnt_q;
        release dut_b.ur_cnt_q;
        ua = ur_a;
        run_frame(1'b0, 16'h0, la, ra, lb, rb, rdy);
        chk("ur sat pulse", {16'd0, 16'(ur_a - ua)}, 32'd1);
        chk("ur sat count", {a_underrun_count, b_underrun_count},
            32'hFFFFFFFF);

        // asynchronous reset in the middle of a word
        try_push(16'hFFFF, pa, pb);
        try_push(16'hFFFF, pa, pb);
        for (int k = 0; k < 6; k++) begin
            bclk_cycle(1'b0, 1'b0, 16'h0, sa, sb, rdy);
        end
        chk("mid word high", {30'd0, a_dacdat, b_dacdat}, 32'd3);
        #3 rst_n = 1'b0;
        #1;
        chk("async rst dacdat", {30'd0, a_dacdat, b_dacdat}, 32'd0);
        chk("async rst x_ready", {30'd0, a_x_ready, b_x_ready}, 32'd0);
        chk("async rst count", {a_underrun_count, b_underrun_count}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acc = '0;
        for (int k = 6; k < 32; k++) begin
            bclk_cycle(1'b0, 1'b0, 16'h0, sa, sb, rdy);
            acc = acc | {30'd0, sa, sb};
        end
        for (int k = 0; k < 32; k++) begin
            bclk_cycle(1'b1, 1'b0, 16'h0, sa, sb, rdy);
            acc = acc | {30'd0, sa, sb};
        end
        chk("post rst abandoned word", acc, 32'd0);
        ua = ur_a;
        run_frame(1'b0, 16'h0, la, ra, lb, rb, rdy);
        chk_frame("post rst empty", la, ra, lb, rb, 32'd0, 32'd0);
        chk("post rst ur count", {a_underrun_count, b_underrun_count},
            {16'd1, 16'd1});
        chk("post rst ur pulse", {16'd0, 16'(ur_a - ua)}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
